csr_regfile: RTL and testbench

Machine-mode CSR register file that sits directly downstream of the execute-stage CSR unit. It stores mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mhartid, and the 64-bit mcycle and minstret counters. It supplies the combinational read data the CSR unit consumes as its old-value input, and accepts that unit's registered write (we/waddr/wdata). A second write port from the interrupt controller (clint) handles trap entry and mret.

---
 rtl/csr_pkg.sv | 69 ++++++
 rtl/csr_counter64.sv | 43 ++++
 rtl/csr_regfile.sv | 137 +++++++++++++
 tb/tb_csr_regfile.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR register file.
//   - bus/data width macros (guarded so an outer build can override them)
//   - 12-bit CSR address map, write masks, reset values
//   - write-port request struct and helpers for writability / write masking
`ifndef BUS_ADDR_WIDTH
`define BUS_ADDR_WIDTH 32
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

package csr_pkg;

    localparam int XLEN = 32;

    // machine-mode read/write CSRs
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    // counters
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    // read-only shadows and id
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [XLEN-1:0] MSTATUS_WMASK = 32'h0000_0088;  // MIE, MPIE
    localparam logic [XLEN-1:0] MSTATUS_FIXED = 32'h0000_1800;  // MPP = 2'b11
    localparam logic [XLEN-1:0] MSTATUS_RESET = 32'h0000_1800;
    localparam logic [XLEN-1:0] MIE_WMASK     = 32'h0000_0888;

    // one write port, address already reduced to the decoded 12 bits
    typedef struct packed {
        logic            we;
        logic [11:0]     addr;
        logic [XLEN-1:0] data;
    } csr_wr_t;

    function automatic logic csr_writable(input logic [11:0] a);
        case (a)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // value that will actually be stored for a write of d to a
    function automatic logic [XLEN-1:0] csr_wmask(input logic [11:0] a,
                                                 input logic [XLEN-1:0] d);
        case (a)
            CSR_MSTATUS: return (d & MSTATUS_WMASK) | MSTATUS_FIXED;
            CSR_MIE:     return d & MIE_WMASK;
            CSR_MTVEC:   return d & 32'hFFFF_FFFC;
            CSR_MEPC:    return d & 32'hFFFF_FFFE;
            default:     return d;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit free/event counter with independently writable halves.
//   clk, rst     : clock, async active-high reset (clears to 0)
//   inc          : add 1 this cycle
//   lo_we, hi_we : replace low / high half with wdata[0] / wdata[1]
//   cnt          : current 64-bit count
// A low-half write suppresses the increment (and thus any carry); a high-half
// write discards the carry out of the low half that cycle.
module csr_counter64
    import csr_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 lo_we,
    input  logic                 hi_we,
    input  logic [1:0][XLEN-1:0] wdata,
    output logic [63:0]          cnt
);

    logic [XLEN-1:0] lo_q, hi_q, lo_inc, lo_d, hi_d;
    logic            carry, lo_en, hi_en;

    always_comb begin
        {carry, lo_inc} = {1'b0, lo_q} + {32'd0, inc};
        lo_en = lo_we | inc;
        lo_d  = lo_we ? wdata[0] : lo_inc;
        hi_en = hi_we | (carry & ~lo_we);
        hi_d  = hi_we ? wdata[1] : hi_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        lo_q <= '0;
        else if (lo_en) lo_q <= lo_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        hi_q <= '0;
        else if (hi_en) hi_q <= hi_d;
    end

    assign cnt = {hi_q, lo_q};

endmodule

// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR storage behind the execute-stage CSR unit.
//   clk, rst                          : clock, async active-high reset
//   raddr_i / rdata_o                 : combinational read, forwards same-cycle writes
//   we_i, waddr_i, wdata_i            : CSR-unit write port
//   clint_we_i, clint_waddr_i/wdata_i : trap-entry / mret write port (wins on collision)
//   inst_retire_i                     : increments minstret
//   mtvec_o, mepc_o, mstatus_o, mie_o : stored values
//   global_int_en_o                   : mstatus.MIE
module csr_regfile
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          HART_ID     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [`BUS_ADDR_WIDTH-1:0] raddr_i,
    output logic [`REG_DATA_WIDTH-1:0] rdata_o,
    input  logic                       we_i,
    input  logic [`BUS_ADDR_WIDTH-1:0] waddr_i,
    input  logic [`REG_DATA_WIDTH-1:0] wdata_i,
    input  logic                       clint_we_i,
    input  logic [`BUS_ADDR_WIDTH-1:0] clint_waddr_i,
    input  logic [`REG_DATA_WIDTH-1:0] clint_wdata_i,
    input  logic                       inst_retire_i,
    output logic [`REG_DATA_WIDTH-1:0] mtvec_o,
    output logic [`REG_DATA_WIDTH-1:0] mepc_o,
    output logic [`REG_DATA_WIDTH-1:0] mstatus_o,
    output logic [`REG_DATA_WIDTH-1:0] mie_o,
    output logic                       global_int_en_o
);

    localparam int NUM_RW  = 7;
    localparam int NUM_CNT = 2;

    // index 0 = mstatus ... index 6 = mtval
    localparam logic [NUM_RW-1:0][11:0] RW_ADDR = {
        CSR_MTVAL, CSR_MCAUSE, CSR_MEPC, CSR_MSCRATCH, CSR_MTVEC, CSR_MIE, CSR_MSTATUS};
    localparam logic [NUM_RW-1:0][XLEN-1:0] RW_RST = {
        32'h0, 32'h0, 32'h0, 32'h0, MTVEC_RESET & 32'hFFFF_FFFC, 32'h0, MSTATUS_RESET};
    // index 0 = mcycle, 1 = minstret
    localparam logic [NUM_CNT-1:0][11:0] CNT_LO = {CSR_MINSTRET,  CSR_MCYCLE};
    localparam logic [NUM_CNT-1:0][11:0] CNT_HI = {CSR_MINSTRETH, CSR_MCYCLEH};

    csr_wr_t                      cwr, uwr;
    logic [NUM_RW-1:0][XLEN-1:0]  rw_q;
    logic [NUM_CNT-1:0][63:0]     cnt;
    logic [NUM_CNT-1:0]           cnt_inc;
    logic [XLEN-1:0]              rd_stored;
    logic [11:0]                  ra;
    logic                         unused_addr_hi;

    function automatic logic port_hit(input csr_wr_t p, input logic [11:0] a);
        return p.we && (p.addr == a);
    endfunction

    // clint data takes priority; the CSR-unit port is already gated off on collision
    function automatic logic [XLEN-1:0] wr_val(input csr_wr_t c, input csr_wr_t u,
                                              input logic [11:0] a);
        return port_hit(c, a) ? csr_wmask(a, c.data) : csr_wmask(a, u.data);
    endfunction

    // Effective write ports: writes to read-only/unmapped addresses never
    // reach storage or forwarding, and the CSR-unit write yields to clint.
    always_comb begin
        cwr.addr = clint_waddr_i[11:0];
        cwr.data = clint_wdata_i;
        cwr.we   = clint_we_i && csr_writable(cwr.addr);
        uwr.addr = waddr_i[11:0];
        uwr.data = wdata_i;
        uwr.we   = we_i && csr_writable(uwr.addr) &&
                   !(clint_we_i && (clint_waddr_i[11:0] == waddr_i[11:0]));
    end

    generate
        for (genvar i = 0; i < NUM_RW; i++) begin : g_rw
            logic            en;
            logic [XLEN-1:0] d, q;
            assign en = port_hit(cwr, RW_ADDR[i]) | port_hit(uwr, RW_ADDR[i]);
            assign d  = wr_val(cwr, uwr, RW_ADDR[i]);
            always_ff @(posedge clk or posedge rst) begin
                if (rst)     q <= RW_RST[i];
                else if (en) q <= d;
            end
            assign rw_q[i] = q;
        end

        assign cnt_inc = {inst_retire_i, 1'b1};

        for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
            csr_counter64 u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (cnt_inc[i]),
                .lo_we (port_hit(cwr, CNT_LO[i]) | port_hit(uwr, CNT_LO[i])),
                .hi_we (port_hit(cwr, CNT_HI[i]) | port_hit(uwr, CNT_HI[i])),
                .wdata ({wr_val(cwr, uwr, CNT_HI[i]), wr_val(cwr, uwr, CNT_LO[i])}),
                .cnt   (cnt[i])
            );
        end
    endgenerate

    assign ra = raddr_i[11:0];

    always_comb begin
        rd_stored = '0;
        case (ra)
            CSR_MSTATUS:                 rd_stored = rw_q[0];
            CSR_MIE:                     rd_stored = rw_q[1];
            CSR_MTVEC:                   rd_stored = rw_q[2];
            CSR_MSCRATCH:                rd_stored = rw_q[3];
            CSR_MEPC:                    rd_stored = rw_q[4];
            CSR_MCAUSE:                  rd_stored = rw_q[5];
            CSR_MTVAL:                   rd_stored = rw_q[6];
            CSR_MCYCLE,   CSR_CYCLE:     rd_stored = cnt[0][31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:    rd_stored = cnt[0][63:32];
            CSR_MINSTRET, CSR_INSTRET:   rd_stored = cnt[1][31:0];
            CSR_MINSTRETH, CSR_INSTRETH: rd_stored = cnt[1][63:32];
            CSR_MHARTID:                 rd_stored = 32'(HART_ID);
            default:                     rd_stored = '0;
        endcase
        // forward the post-mask value of any effective write to this address;
        // counter halves forward the raw written value (mask is identity there)
        if (port_hit(cwr, ra) || port_hit(uwr, ra)) rdata_o = wr_val(cwr, uwr, ra);
        else                                         rdata_o = rd_stored;
    end

    assign mstatus_o       = rw_q[0];
    assign mie_o           = rw_q[1];
    assign mtvec_o         = rw_q[2];
    assign mepc_o          = rw_q[4];
    assign global_int_en_o = rw_q[0][3];

    assign unused_addr_hi = ^{raddr_i[`BUS_ADDR_WIDTH-1:12], waddr_i[`BUS_ADDR_WIDTH-1:12],
                              clint_waddr_i[`BUS_ADDR_WIDTH-1:12]};

endmodule

// File: tb/tb_csr_regfile.sv
`ifndef BUS_ADDR_WIDTH
`define BUS_ADDR_WIDTH 32
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module tb_csr_regfile;

    localparam logic [31:0] MTVEC_RST = 32'h8000_0103;
    localparam int          HART      = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] raddr_i, waddr_i, wdata_i, clint_waddr_i, clint_wdata_i;
    logic        we_i, clint_we_i, inst_retire_i;
    logic [31:0] rdata_o, mtvec_o, mepc_o, mstatus_o, mie_o;
    logic        global_int_en_o;

    int n_vec = 0;
    int n_err = 0;

    csr_regfile #(.MTVEC_RESET(MTVEC_RST), .HART_ID(HART)) dut (
        .clk(clk), .rst(rst),
        .raddr_i(raddr_i), .rdata_o(rdata_o),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .clint_we_i(clint_we_i), .clint_waddr_i(clint_waddr_i), .clint_wdata_i(clint_wdata_i),
        .inst_retire_i(inst_retire_i),
        .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mstatus_o(mstatus_o), .mie_o(mie_o),
        .global_int_en_o(global_int_en_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] raddr;
        logic        we;
        logic [31:0] waddr, wdata;
        logic        cwe;
        logic [31:0] caddr, cdata;
        logic [31:0] exp_rd;                         // before the edge
        logic [31:0] exp_ms, exp_mie, exp_mtvec, exp_mepc;  // after the edge
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] ra, logic w, logic [31:0] wa, wd,
                                logic cw, logic [31:0] ca, cd, logic [31:0] rd,
                                logic [31:0] ms, mie, mtvec, mepc);
        vec_t v;
        v.raddr = ra; v.we = w; v.waddr = wa; v.wdata = wd;
        v.cwe = cw; v.caddr = ca; v.cdata = cd; v.exp_rd = rd;
        v.exp_ms = ms; v.exp_mie = mie; v.exp_mtvec = mtvec; v.exp_mepc = mepc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ra, input logic w, input logic [31:0] wa, wd,
                         input logic cw, input logic [31:0] ca, cd, input logic ret);
        raddr_i = ra; we_i = w; waddr_i = wa; wdata_i = wd;
        clint_we_i = cw; clint_waddr_i = ca; clint_wdata_i = cd; inst_retire_i = ret;
    endtask

    initial begin
        rst = 1'b1;
        drive(32'h0, 0, 0, 0, 0, 0, 0, 0);

        // raddr, we, waddr, wdata, cwe, caddr, cdata, exp_rd | mstatus, mie, mtvec, mepc
        vecs.push_back(mk(32'h300, 0, 0, 0, 0, 0, 0, 32'h0000_1800, 32'h1800, 0, 32'h8000_0100, 0));
        vecs.push_back(mk(32'h305, 0, 0, 0, 0, 0, 0, 32'h8000_0100, 32'h1800, 0, 32'h8000_0100, 0));
        vecs.push_back(mk(32'hF14, 0, 0, 0, 0, 0, 0, 32'h0000_0003, 32'h1800, 0, 32'h8000_0100, 0));
        vecs.push_back(mk(32'h300, 1, 32'h300, 32'hFFFF_FFFF, 0, 0, 0, 32'h0000_1888,
                          32'h1888, 0, 32'h8000_0100, 0));
        vecs.push_back(mk(32'h341, 1, 32'h341, 32'h1111_1111, 1, 32'h341, 32'h2222_2223,
                          32'h2222_2222, 32'h1888, 0, 32'h8000_0100, 32'h2222_2222));
        vecs.push_back(mk(32'h341, 0, 0, 0, 0, 0, 0, 32'h2222_2222,
                          32'h1888, 0, 32'h8000_0100, 32'h2222_2222));
        vecs.push_back(mk(32'h304, 1, 32'h304, 32'hFFFF_FFFF, 0, 0, 0, 32'h0000_0888,
                          32'h1888, 32'h888, 32'h8000_0100, 32'h2222_2222));
        vecs.push_back(mk(32'h305, 1, 32'h305, 32'h1234_5677, 0, 0, 0, 32'h1234_5674,
                          32'h1888, 32'h888, 32'h1234_5674, 32'h2222_2222));
        vecs.push_back(mk(32'h340, 1, 32'h340, 32'hDEAD_BEEF, 1, 32'h342, 32'h8000_000B,
                          32'hDEAD_BEEF, 32'h1888, 32'h888, 32'h1234_5674, 32'h2222_2222));
        vecs.push_back(mk(32'h342, 0, 0, 0, 0, 0, 0, 32'h8000_000B,
                          32'h1888, 32'h888, 32'h1234_5674, 32'h2222_2222));
        vecs.push_back(mk(32'h340, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF,
                          32'h1888, 32'h888, 32'h1234_5674, 32'h2222_2222));
        vecs.push_back(mk(32'h343, 1, 32'h343, 32'hCAFE_F00D, 1, 32'h300, 32'h0,
                          32'hCAFE_F00D, 32'h1800, 32'h888, 32'h1234_5674, 32'h2222_2222));
        vecs.push_back(mk(32'h343, 0, 0, 0, 0, 0, 0, 32'hCAFE_F00D,
                          32'h1800, 32'h888, 32'h1234_5674, 32'h2222_2222));
        vecs.push_back(mk(32'h7C0, 1, 32'h7C0, 32'hAAAA_5555, 0, 0, 0, 32'h0,
                          32'h1800, 32'h888, 32'h1234_5674, 32'h2222_2222));
        vecs.push_back(mk(32'hF14, 1, 32'hF14, 32'h0, 0, 0, 0, 32'h3,
                          32'h1800, 32'h888, 32'h1234_5674, 32'h2222_2222));
        vecs.push_back(mk(32'hABC0_0300, 0, 0, 0, 0, 0, 0, 32'h1800,
                          32'h1800, 32'h888, 32'h1234_5674, 32'h2222_2222));
        vecs.push_back(mk(32'h341, 1, 32'h0001_0341, 32'h5, 0, 0, 0, 32'h4,
                          32'h1800, 32'h888, 32'h1234_5674, 32'h4));
        vecs.push_back(mk(32'h300, 1, 32'h300, 32'hFFFF_FFFF, 1, 32'h300, 32'h80, 32'h1880,
                          32'h1880, 32'h888, 32'h1234_5674, 32'h4));

        // reset state
        #12;
        chk("rst mstatus", mstatus_o, 32'h0000_1800);
        chk("rst gie", {31'd0, global_int_en_o}, 32'h0);
        chk("rst mie", mie_o, 32'h0);
        chk("rst mepc", mepc_o, 32'h0);
        chk("rst mtvec", mtvec_o, 32'h8000_0100);
        raddr_i = 32'hB00; #1;
        chk("rst mcycle", rdata_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].raddr, vecs[i].we, vecs[i].waddr, vecs[i].wdata,
                  vecs[i].cwe, vecs[i].caddr, vecs[i].cdata, 1'b0);
            #1 chk($sformatf("v%0d rdata", i), rdata_o, vecs[i].exp_rd);
            @(posedge clk); #1;
            chk($sformatf("v%0d mstatus", i), mstatus_o, vecs[i].exp_ms);
            chk($sformatf("v%0d gie", i), {31'd0, global_int_en_o}, {31'd0, vecs[i].exp_ms[3]});
            chk($sformatf("v%0d mie", i), mie_o, vecs[i].exp_mie);
            chk($sformatf("v%0d mtvec", i), mtvec_o, vecs[i].exp_mtvec);
            chk($sformatf("v%0d mepc", i), mepc_o, vecs[i].exp_mepc);
        end

        // mcycle low wrap carries into the high half
        @(negedge clk); drive(32'hB00, 1, 32'hB00, 32'hFFFF_FFFE, 0, 0, 0, 0);
        #1 chk("mcycle fwd", rdata_o, 32'hFFFF_FFFE);
        @(negedge clk); drive(32'hB00, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #1 chk("mcycle wrap lo", rdata_o, 32'h0);
        raddr_i = 32'hB80; #1 chk("mcycleh carry", rdata_o, 32'h1);
        raddr_i = 32'hC80; #1 chk("cycleh shadow", rdata_o, 32'h1);

        // high-half write discards the carry out of the wrapping low half
        @(negedge clk); drive(32'hB00, 1, 32'hB00, 32'hFFFF_FFFF, 0, 0, 0, 0);
        @(negedge clk); drive(32'hB80, 1, 32'hB80, 32'h10, 0, 0, 0, 0);
        #1 chk("mcycleh fwd", rdata_o, 32'h10);
        @(negedge clk); drive(32'hB00, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("mcycle lo after hi wr", rdata_o, 32'h0);
        raddr_i = 32'hB80; #1 chk("mcycleh no carry", rdata_o, 32'h10);

        // read-only shadow write dropped, no forwarding
        @(negedge clk); drive(32'hC80, 1, 32'hC80, 32'h5555, 0, 0, 0, 0);
        #1 chk("ro no fwd", rdata_o, 32'h10);
        @(negedge clk); drive(32'hB80, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("ro write dropped", rdata_o, 32'h10);

        // minstret: 5 retire pulses across 10 cycles
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); inst_retire_i = (k % 2 == 0);
        end
        @(negedge clk); drive(32'hB02, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("minstret 5", rdata_o, 32'h5);
        raddr_i = 32'hC02; #1 chk("instret shadow", rdata_o, 32'h5);
        raddr_i = 32'hB82; #1 chk("minstreth", rdata_o, 32'h0);

        // write wins over retire increment
        @(negedge clk); drive(32'hB02, 1, 32'hB02, 32'd100, 0, 0, 0, 1);
        #1 chk("minstret fwd", rdata_o, 32'd100);
        @(negedge clk); drive(32'hB02, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("minstret wr no inc", rdata_o, 32'd100);

        // async reset mid-operation; in-flight write lost
        @(negedge clk); drive(32'hB00, 1, 32'h300, 32'hFFFF_FFFF, 0, 0, 0, 1);
        #2 rst = 1'b1;
        #1 chk("async rst mstatus", mstatus_o, 32'h1800);
        chk("async rst mcycle", rdata_o, 32'h0);
        @(posedge clk); #1;
        chk("rst write lost", mstatus_o, 32'h1800);
        chk("rst mie", mie_o, 32'h0);
        @(negedge clk); rst = 1'b0; drive(32'hB00, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("post rst mcycle", rdata_o, 32'h0);
        raddr_i = 32'h340; #1 chk("post rst mscratch", rdata_o, 32'h0);
        raddr_i = 32'hB00;
        @(posedge clk); #1 chk("first inc", rdata_o, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
